// File: rtl/seg_scan_if.sv
// Display bus for seg_scan: word/strobe in, digit/segment drive and frame pulse out.
// With SEG_SCAN_BLINK_EN defined the per-digit blink mask rides on the same bus.
interface seg_scan_if;
  logic [31:0] din;
  logic        din_vld;
  logic [7:0]  sel;
  logic [7:0]  seg;
  logic        frame_done;
`ifdef SEG_SCAN_BLINK_EN
  logic [7:0]  blink;

  modport master (output din, din_vld, blink, input sel, seg, frame_done);
  modport slave  (input din, din_vld, blink, output sel, seg, frame_done);
`else
  modport master (output din, din_vld, input sel, seg, frame_done);
  modport slave  (input din, din_vld, output sel, seg, frame_done);
`endif
endinterface

// File: rtl/seg_scan.sv
// Time-multiplexed 8-digit common-anode 7-segment scanner with frame-aligned word updates.
// Optional per-digit blinking is compiled in with `define SEG_SCAN_BLINK_EN.
module seg_scan #(
  parameter int SLOT_CYC  = 50_000,
  parameter int BLANK_CYC = 500,
  parameter int BLINK_CYC = 25_000_000
) (
  input  logic        clk,
  input  logic        rst,
  seg_scan_if.slave   bus
);

  // Handshake: din_vld is a single-cycle strobe that is always accepted; there is no ready.
  localparam int CW = (SLOT_CYC > 2) ? $clog2(SLOT_CYC) : 1;
  localparam logic [CW-1:0] CNT_LAST  = CW'(SLOT_CYC - 1);
  localparam logic [CW-1:0] CNT_PRE   = CW'(SLOT_CYC - 2);
  localparam logic [CW-1:0] BLANK_END = CW'(BLANK_CYC);

  logic [CW-1:0] cnt;
  logic [2:0]    idx;
  logic [31:0]   staging;
  logic [31:0]   shadow;
  logic          pending;
  logic          slot_end;
  logic          frame_end;
  logic [3:0]    nib;
  logic [7:0]    sel_d;
  logic [7:0]    seg_d;

  function automatic logic [7:0] decode(input logic [3:0] v);
    logic [7:0] s;
    case (v)
      4'h0: s = 8'hC0;
      4'h1: s = 8'hF9;
      4'h2: s = 8'hA4;
      4'h3: s = 8'hB0;
      4'h4: s = 8'h99;
      4'h5: s = 8'h92;
      4'h6: s = 8'h82;
      4'h7: s = 8'hF8;
      4'h8: s = 8'h80;
      4'h9: s = 8'h90;
      4'hA: s = 8'hBF;
      default: s = 8'hFF;
    endcase
    return s;
  endfunction

`ifdef SEG_SCAN_BLINK_EN
  localparam int BW = (BLINK_CYC > 2) ? $clog2(BLINK_CYC) : 1;
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_CYC - 1);

  logic [BW-1:0] bcnt;
  logic          phase;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bcnt  <= '0;
      phase <= 1'b0;
    end else if (bcnt == BLINK_LAST) begin
      bcnt  <= '0;
      phase <= ~phase;
    end else begin
      bcnt <= bcnt + 1'b1;
    end
  end
`endif

  assign slot_end  = (cnt == CNT_LAST);
  assign frame_end = slot_end && (idx == 3'd7);
  assign nib       = shadow[{idx, 2'b00} +: 4];

  always_comb begin
    sel_d = 8'hFF;
    seg_d = 8'hFF;
    if (cnt >= BLANK_END) begin
      sel_d = ~(8'h01 << idx);
      seg_d = decode(nib);
`ifdef SEG_SCAN_BLINK_EN
      if (phase && bus.blink[idx]) seg_d = 8'hFF;
`endif
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt            <= '0;
      idx            <= '0;
      staging        <= '0;
      shadow         <= '0;
      pending        <= 1'b0;
      bus.sel        <= 8'hFF;
      bus.seg        <= 8'hFF;
      bus.frame_done <= 1'b0;
    end else begin
      if (slot_end) begin
        cnt <= '0;
        idx <= idx + 1'b1;
      end else begin
        cnt <= cnt + 1'b1;
      end

      if (bus.din_vld) begin
        staging <= bus.din;
        pending <= 1'b1;
      end
      // A strobe landing on the frame boundary itself bypasses staging.
      if (frame_end) begin
        if (bus.din_vld) begin
          shadow  <= bus.din;
          pending <= 1'b0;
        end else if (pending) begin
          shadow  <= staging;
          pending <= 1'b0;
        end
      end

      bus.sel        <= sel_d;
      bus.seg        <= seg_d;
      // Registered one cycle early so the pulse lines up with the last digit-7 cycle.
      bus.frame_done <= (cnt == CNT_PRE) && (idx == 3'd7);
    end
  end

endmodule

// File: tb/tb_seg_scan.sv
// Self-checking bench for seg_scan: table-driven frame checks, corner-case sequences and
// randomized strobes compared against a cycle-position reference model.
module tb_seg_scan;

  localparam int SLOT  = 10;
  localparam int BLANK = 2;
  localparam int BLINK = 40;
  localparam int FRAME = 8 * SLOT;

  typedef struct {
    logic [31:0] word;
    logic [63:0] segs;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;

  seg_scan_if bus ();

  seg_scan #(.SLOT_CYC(SLOT), .BLANK_CYC(BLANK), .BLINK_CYC(BLINK)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  int unsigned vectors = 0;
  int unsigned errors  = 0;

  // Reference model: position in the frame is derived from the edge count since release.
  int unsigned n      = 0;
  int unsigned last_p = 999;
  logic [31:0] shown  = '0;
  logic [31:0] latest = '0;
  bit          have   = 0;
  logic [7:0]  dec_tab [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                                8'h80, 8'h90, 8'hBF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
  logic [7:0]  exp_q [$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at edge %0d: got %h expected %h", name, n, act, exp);
    end
  endtask

  task automatic model_reset();
    n      = 0;
    last_p = FRAME - 1;
    shown  = '0;
    latest = '0;
    have   = 0;
  endtask

  task automatic tick(input logic vld, input logic [31:0] word);
    int unsigned p, d, c;
    logic [7:0]  es, el;
    logic        ef;
    bus.din_vld = vld;
    bus.din     = word;
    @(posedge clk);
    p  = n % FRAME;
    d  = p / SLOT;
    c  = p % SLOT;
    es = 8'hFF;
    el = 8'hFF;
    if (c >= BLANK) begin
      es = ~(8'h01 << d);
      el = dec_tab[shown[d*4 +: 4]];
`ifdef SEG_SCAN_BLINK_EN
      if (((n / BLINK) % 2) == 1 && bus.blink[d]) el = 8'hFF;
`endif
    end
    ef = (p == FRAME - 2);
    if (vld) begin
      latest = word;
      have   = 1;
    end
    if (p == FRAME - 1) begin
      if (have) shown = latest;
      have = 0;
    end
    n++;
    last_p = p;
    @(negedge clk);
    bus.din_vld = 1'b0;
    check("sel", {24'h0, bus.sel}, {24'h0, es});
    check("seg", {24'h0, bus.seg}, {24'h0, el});
    check("frame_done", {31'h0, bus.frame_done}, {31'h0, ef});
  endtask

  task automatic run_to(input int unsigned target);
    for (int i = 0; i < 2 * FRAME && last_p != target; i++) tick(1'b0, 32'h0);
    check("run_to_bound", last_p, target);
  endtask

  // Expects last_p == FRAME-1; checks one full frame against an 8-digit segment record.
  task automatic check_frame(input logic [63:0] segs);
    for (int k = 0; k < 8; k++) exp_q.push_back(segs[k*8 +: 8]);
    for (int i = 0; i < FRAME; i++) begin
      tick(1'b0, 32'h0);
      if (last_p % SLOT == 5 && exp_q.size() > 0) check("frame_seg", {24'h0, bus.seg}, {24'h0, exp_q.pop_front()});
    end
  endtask

  vec_t table_v [4];

  initial begin
    logic [31:0] w;
    table_v[0] = '{32'h12A34A56, 64'hF9A4BFB099BF9282};
    table_v[1] = '{32'h01234567, 64'hC0F9A4B0999282F8};
    table_v[2] = '{32'h89ABCDEF, 64'h8090BFFFFFFFFFFF};
    table_v[3] = '{32'h00000000, 64'hC0C0C0C0C0C0C0C0};

    bus.din     = '0;
    bus.din_vld = 1'b0;
`ifdef SEG_SCAN_BLINK_EN
    bus.blink   = 8'h00;
`endif
    repeat (3) @(negedge clk);
    check("reset_sel", {24'h0, bus.sel}, 32'hFF);
    check("reset_seg", {24'h0, bus.seg}, 32'hFF);
    check("reset_frame_done", {31'h0, bus.frame_done}, 32'h0);
    rst = 1'b0;
    model_reset();

    // First frame after release: every digit shows zero.
    check_frame(64'hC0C0C0C0C0C0C0C0);
    run_to(35);
    check("digit3_sel", {24'h0, bus.sel}, 32'hF7);

    // Table: strobe mid-frame, old word finishes the frame, new word fills the next.
    for (int t = 0; t < 4; t++) begin
      run_to(40);
      tick(1'b1, table_v[t].word);
      run_to(FRAME - 1);
      check_frame(table_v[t].segs);
    end

    // Last strobe in a frame wins.
    run_to(20);
    tick(1'b1, 32'h11111111);
    run_to(50);
    tick(1'b1, 32'h22222222);
    run_to(FRAME - 1);
    check_frame(64'hA4A4A4A4A4A4A4A4);

    // Strobe on the frame_done cycle takes effect in the very next frame.
    run_to(FRAME - 2);
    check("frame_done_seen", {31'h0, bus.frame_done}, 32'h1);
    tick(1'b1, 32'h99999999);
    check_frame(64'h9090909090909090);

    // Asynchronous reset mid-slot.
    run_to(33);
    #2 rst = 1'b1;
    #1;
    check("async_sel", {24'h0, bus.sel}, 32'hFF);
    check("async_seg", {24'h0, bus.seg}, 32'hFF);
    check("async_frame_done", {31'h0, bus.frame_done}, 32'h0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    model_reset();
    check_frame(64'hC0C0C0C0C0C0C0C0);

`ifdef SEG_SCAN_BLINK_EN
    bus.blink = 8'h01;
    for (int i = 0; i < 2 * FRAME; i++) tick(1'b0, 32'h0);
`endif

    // Randomized strobes and words checked cycle by cycle against the model.
    for (int i = 0; i < 800; i++) begin
`ifdef SEG_SCAN_BLINK_EN
      if (last_p == FRAME - 1) bus.blink = 8'($urandom_range(0, 255));
`endif
      w = $urandom;
      tick($urandom_range(0, 14) == 0, w);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
